counter_checker: RTL and testbench
==================================

Name: counter_checker

Overview:
- Receive-side checker for a free-running binary counter bus, such as an LED counter output looped back into fabric.
- Samples the bus on a strobe and verifies that each sample equals the previous sample + 1 (mod 2^WIDTH).
- Reports lock, a sticky error flag and a saturating error count.
- Used in on-device install/feature tests as the self-check counterpart of a counter design.

Parameters:
WIDTH, 4, width of the monitored counter bus
LOCK_CNT, 4, consecutive correct increments required to assert locked (legal range 1..255)
ERR_W, 8, width of err_count; saturates at 2^ERR_W-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
sample_en  input  1  strobe; din is sampled on a rising clk edge where sample_en=1
din  input  WIDTH  monitored counter value
err_clr  input  1  synchronous clear of error and err_count
locked  output  1  high while the stream is tracked and verified
error  output  1  sticky; set on the first mismatch while locked
err_count  output  ERR_W  number of mismatches detected while locked, saturating
last_val  output  WIDTH  most recently sampled din

Behaviour:
- rst=1, asynchronous: state=SEARCH, run=0, last_val=0, locked=0, error=0, err_count=0. Release of rst is synchronous to clk.
- All outputs are registered. The effect of a sample is visible one clk after the edge that captured it.
- Edges with sample_en=0 change nothing except the err_clr action.
- Expected value: exp = last_val + 1, truncated to WIDTH bits. Wrap 2^WIDTH-1 -> 0 is a correct increment.
- Every sample loads last_val <= din, in every state.
- SEARCH:
  - first sample -> TRACK, run=0.
- TRACK:
  - din==exp -> run+1.
  - When run reaches LOCK_CNT -> LOCKED, locked=1 on the same update.
  - din!=exp -> run=0, stay in TRACK, resync on din. No error is recorded.
- LOCKED:
  - din==exp -> stay.
  - din!=exp -> error=1, err_count+1 (holds at max), state=TRACK, run=0, locked=0.
- err_clr=1 clears error and err_count on that edge regardless of sample_en.
- Simultaneous err_clr and LOCKED mismatch: the clear applies first, then the new error. Result: error=1, err_count=1.
- err_clr does not affect state, run, locked or last_val.
- run counter is 8 bits wide and never exceeds LOCK_CNT.
- Reset mid-stream: returns to SEARCH. The first post-reset sample is never checked.

Optional Feature:
- Macro: COUNTER_CHECKER_WRAP_CNT_EN.
- Defined:
  - Adds output wrap_count [7:0], reset 0.
  - Increments (modulo 256) on each correct sample, in LOCKED state, where last_val=2^WIDTH-1 and din=0.
  - Cleared by err_clr.
- Undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then samples 0,1,2,3,4 with one sample_en pulse per 4 clks -> locked=1 one clk after the sample 4 edge, error=0, err_count=0, last_val=4.
- Locked, then feed 14,15,0,1 -> stays locked, error=0. With the macro: wrap_count=1.
- Locked at 5, then feed 9 -> locked=0, error=1, err_count=1, last_val=9. Then feed 10..13 -> locked=1 again, error stays 1.
- In TRACK, samples 0,1,7,8,9,10,11 -> no error and err_count=0. locked=1 after sample 11.
- Mismatch while locked with err_clr=1 on the same edge -> err_count=1, error=1. Then err_clr alone -> error=0, err_count=0, locked unchanged.
- Assert rst asynchronously mid-stream between clk edges -> all outputs 0 immediately. Next sample is not checked, and a lock needs LOCK_CNT further correct increments.
- ERR_W=2: force 5 locked mismatches, relocking between each -> err_count saturates at 3.

Source files
------------

// File: rtl/counter_checker.sv
// Receive-side checker for a free-running counter bus: tracks samples, verifies +1 steps, reports lock/errors.
// Latency: every output is registered and reflects a captured sample one clk after its capture edge.
// Backpressure: none; din is sampled on every edge with sample_en=1 and err_clr acts on any edge.
// Optional: define COUNTER_CHECKER_WRAP_CNT_EN to add the wrap_count output (verified wraps while locked).
module counter_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] last_val
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
  ,
  output logic [7:0]       wrap_count
`endif
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_TARGET = 8'(LOCK_CNT);

  state_t           state, state_d;
  logic [7:0]       run, run_d;
  logic             locked_d;
  logic             error_d;
  logic [ERR_W-1:0] err_count_d;
  logic [WIDTH-1:0] last_val_d;
  logic [WIDTH-1:0] exp_val;
  logic [7:0]       run_inc;
  logic             match;
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
  logic [7:0]       wrap_count_d;
`endif

  assign exp_val = last_val + WIDTH'(1);
  assign match   = (din == exp_val);
  assign run_inc = run + 8'd1;

  // Next-state and next-output computation; clear applies before any new error.
  always_comb begin
    state_d      = state;
    run_d        = run;
    locked_d     = locked;
    error_d      = error;
    err_count_d  = err_count;
    last_val_d   = last_val;
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
    wrap_count_d = wrap_count;
`endif

    if (err_clr) begin
      error_d     = 1'b0;
      err_count_d = '0;
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
      wrap_count_d = 8'd0;
`endif
    end

    if (sample_en) begin
      last_val_d = din;
      case (state)
        SEARCH: begin
          // First sample after reset only seeds last_val; it is never checked.
          state_d = TRACK;
          run_d   = 8'd0;
        end
        TRACK: begin
          if (match) begin
            if (run_inc >= LOCK_TARGET) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              run_d    = LOCK_TARGET;
            end else begin
              run_d = run_inc;
            end
          end else begin
            // Resync silently on the new value; errors only count once locked.
            run_d = 8'd0;
          end
        end
        LOCKED: begin
          if (match) begin
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
            if ((&last_val) && (din == '0)) begin
              wrap_count_d = wrap_count_d + 8'd1;
            end
`endif
          end else begin
            error_d  = 1'b1;
            if (!(&err_count_d)) begin
              err_count_d = err_count_d + ERR_W'(1);
            end
            state_d  = TRACK;
            run_d    = 8'd0;
            locked_d = 1'b0;
          end
        end
        default: begin
          state_d  = SEARCH;
          run_d    = 8'd0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      run        <= 8'd0;
      locked     <= 1'b0;
      error      <= 1'b0;
      err_count  <= '0;
      last_val   <= '0;
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
      wrap_count <= 8'd0;
`endif
    end else begin
      state      <= state_d;
      run        <= run_d;
      locked     <= locked_d;
      error      <= error_d;
      err_count  <= err_count_d;
      last_val   <= last_val_d;
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
      wrap_count <= wrap_count_d;
`endif
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// Directed self-checking bench for counter_checker: vector table plus hand sequences.
// Latency: outputs are compared on the falling edge after the capture edge.
// Backpressure: not applicable; the bench drives sample_en/err_clr directly.
module tb_counter_checker;

  logic       clk;
  logic       rst;
  logic       sample_en;
  logic [3:0] din;
  logic       err_clr;

  logic       locked, error;
  logic [7:0] err_count;
  logic [3:0] last_val;
  logic       locked2, error2;
  logic [1:0] err_count2;
  logic [3:0] last_val2;
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
  logic [7:0] wrap_count, wrap_count2;
`endif

  int checks = 0;
  int errors = 0;

  counter_checker #(.WIDTH(4), .LOCK_CNT(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .din(din), .err_clr(err_clr),
    .locked(locked), .error(error), .err_count(err_count), .last_val(last_val)
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
    , .wrap_count(wrap_count)
`endif
  );

  counter_checker #(.WIDTH(4), .LOCK_CNT(4), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .sample_en(sample_en), .din(din), .err_clr(err_clr),
    .locked(locked2), .error(error2), .err_count(err_count2), .last_val(last_val2)
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
    , .wrap_count(wrap_count2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] d;
    logic       clr;
    logic       lk;
    logic       er;
    logic [7:0] cnt;
    logic [3:0] lv;
    logic [7:0] wc;
  } vec_t;

  vec_t tbl[$];
  int   seg_a_end;

  task automatic add(input logic en, input logic [3:0] d, input logic clr,
                     input logic lk, input logic er, input logic [7:0] cnt,
                     input logic [3:0] lv, input logic [7:0] wc);
    vec_t v;
    v.en = en; v.d = d; v.clr = clr; v.lk = lk; v.er = er;
    v.cnt = cnt; v.lv = lv; v.wc = wc;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Caller sits on a falling edge; drive, let one rising edge pass, then return on the next falling edge.
  task automatic smp(input logic [3:0] d);
    sample_en = 1'b1;
    din       = d;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic run_vectors(input int from, input int to);
    for (int i = from; i < to; i++) begin
      sample_en = tbl[i].en;
      din       = tbl[i].d;
      err_clr   = tbl[i].clr;
      @(negedge clk);
      check($sformatf("vec%0d.locked", i), 32'(locked), 32'(tbl[i].lk));
      check($sformatf("vec%0d.error", i), 32'(error), 32'(tbl[i].er));
      check($sformatf("vec%0d.err_count", i), 32'(err_count), 32'(tbl[i].cnt));
      check($sformatf("vec%0d.last_val", i), 32'(last_val), 32'(tbl[i].lv));
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
      check($sformatf("vec%0d.wrap_count", i), 32'(wrap_count), 32'(tbl[i].wc));
`endif
    end
    sample_en = 1'b0;
    err_clr   = 1'b0;
  endtask

  initial begin
    logic [3:0] v;
    logic [3:0] m;
    int         exp2;

    // Segment A: lock-up with sparse strobes, wrap, mismatch/relock, clear interplay.
    for (int i = 0; i <= 4; i++) begin
      add(1'b1, 4'(i), 1'b0, (i == 4), 1'b0, 8'd0, 4'(i), 8'd0);
      for (int k = 0; k < 3; k++) add(1'b0, 4'd0, 1'b0, (i == 4), 1'b0, 8'd0, 4'(i), 8'd0);
    end
    for (int i = 5; i <= 15; i++) add(1'b1, 4'(i), 1'b0, 1'b1, 1'b0, 8'd0, 4'(i), 8'd0);
    for (int i = 0; i <= 5; i++)  add(1'b1, 4'(i), 1'b0, 1'b1, 1'b0, 8'd0, 4'(i), 8'd1);
    add(1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 8'd1, 4'd9,  8'd1);
    add(1'b1, 4'd10, 1'b0, 1'b0, 1'b1, 8'd1, 4'd10, 8'd1);
    add(1'b1, 4'd11, 1'b0, 1'b0, 1'b1, 8'd1, 4'd11, 8'd1);
    add(1'b1, 4'd12, 1'b0, 1'b0, 1'b1, 8'd1, 4'd12, 8'd1);
    add(1'b1, 4'd13, 1'b0, 1'b1, 1'b1, 8'd1, 4'd13, 8'd1);
    add(1'b1, 4'd3,  1'b1, 1'b0, 1'b1, 8'd1, 4'd3,  8'd0);
    add(1'b1, 4'd4,  1'b0, 1'b0, 1'b1, 8'd1, 4'd4,  8'd0);
    add(1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 8'd1, 4'd5,  8'd0);
    add(1'b1, 4'd6,  1'b0, 1'b0, 1'b1, 8'd1, 4'd6,  8'd0);
    add(1'b1, 4'd7,  1'b0, 1'b1, 1'b1, 8'd1, 4'd7,  8'd0);
    add(1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 8'd0, 4'd7,  8'd0);
    add(1'b1, 4'd8,  1'b0, 1'b1, 1'b0, 8'd0, 4'd8,  8'd0);
    add(1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 8'd1, 4'd2,  8'd0);
    seg_a_end = tbl.size();
    // Segment B (after async reset): first sample unchecked, resync in TRACK, then lock.
    add(1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'd0, 4'd0,  8'd0);
    add(1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 8'd0, 4'd1,  8'd0);
    add(1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 8'd0, 4'd7,  8'd0);
    add(1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 8'd0, 4'd8,  8'd0);
    add(1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 8'd0, 4'd9,  8'd0);
    add(1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 8'd0, 4'd10, 8'd0);
    add(1'b1, 4'd11, 1'b0, 1'b1, 1'b0, 8'd0, 4'd11, 8'd0);

    rst = 1'b1; sample_en = 1'b0; din = 4'd0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.locked", 32'(locked), 32'd0);
    check("reset.error", 32'(error), 32'd0);
    check("reset.err_count", 32'(err_count), 32'd0);
    check("reset.last_val", 32'(last_val), 32'd0);
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
    check("reset.wrap_count", 32'(wrap_count), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_vectors(0, seg_a_end);

    // Async reset between edges while error is set: outputs clear without a clock edge.
    check("pre_rst.error", 32'(error), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst.locked", 32'(locked), 32'd0);
    check("async_rst.error", 32'(error), 32'd0);
    check("async_rst.err_count", 32'(err_count), 32'd0);
    check("async_rst.last_val", 32'(last_val), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_vectors(seg_a_end, tbl.size());

    // Repeated locked mismatches with relock in between; narrow counter must saturate.
    v = 4'd11;
    for (int k = 1; k <= 5; k++) begin
      m = v + 4'd5;
      smp(m);
      exp2 = (k > 3) ? 3 : k;
      check($sformatf("sat%0d.locked", k), 32'(locked), 32'd0);
      check($sformatf("sat%0d.err_count", k), 32'(err_count), 32'(k));
      check($sformatf("sat%0d.err_count2", k), 32'(err_count2), 32'(exp2));
      for (int j = 1; j <= 4; j++) smp(m + 4'(j));
      v = m + 4'd4;
      check($sformatf("sat%0d.relock", k), 32'(locked2), 32'd1);
    end
    check("sat.error2", 32'(error2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
